// File: rtl/mod_mult_serial.sv
// ============================================================================
// Module  : mod_mult_serial
// Brief   : Digit-serial modular multiplier z = (a*b) mod M, MSD-first on b,
//           D bits per cycle, with valid/ready handshakes on both sides.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module mod_mult_serial #(
    parameter int M = 2011,
    parameter int W = 11,
    parameter int D = 6
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_a,
    input  logic [W-1:0] in_b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_z,
    output logic         out_err
);

    localparam int NDIG = (W + D - 1) / D;
    localparam int NB   = NDIG * D;
    localparam int XW   = W + D + 1;
    localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;

    localparam logic [W-1:0]  c_mod   = W'(M);
    localparam logic [XW-1:0] c_mod_x = XW'(M);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t         r_state;
    state_t         w_next;

    logic [W-1:0]   r_a;
    logic [NB-1:0]  r_b;
    logic [W-1:0]   r_acc;
    logic [CW-1:0]  r_cnt;
    logic           r_err;
    logic [W-1:0]   r_z;
    logic           r_zerr;

    logic           w_accept;
    logic           w_last;
    logic [D-1:0]   w_digit;
    logic [XW-1:0]  w_sum;
    logic [XW-1:0]  w_red [0:D];
    logic [W-1:0]   w_next_acc;

    assign w_accept = in_valid && (r_state == S_IDLE);
    assign w_last   = (r_cnt == '0);
    assign w_digit  = r_b[NB-1 -: D];

    // acc*2^D + a*d stays below M*2^(D+1), so the quotient fits in D+1 bits.
    assign w_sum    = XW'({r_acc, {D{1'b0}}}) + XW'(r_a) * XW'(w_digit);
    assign w_red[0] = w_sum;

    // Restoring compare/subtract ladder: remove M*2^k for k = D down to 1.
    generate
        for (genvar gi = 0; gi < D; gi++) begin : g_red
            localparam logic [XW-1:0] c_sub = c_mod_x << (D - gi);
            assign w_red[gi+1] = (w_red[gi] >= c_sub) ? (w_red[gi] - c_sub) : w_red[gi];
        end
    endgenerate

    assign w_next_acc = (w_red[D] >= c_mod_x) ? W'(w_red[D] - c_mod_x) : w_red[D][W-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (in_valid)  w_next = S_RUN;
            S_RUN:   if (w_last)    w_next = S_DONE;
            S_DONE:  if (out_ready) w_next = S_IDLE;
            default:                w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a    <= '0;
            r_b    <= '0;
            r_acc  <= '0;
            r_cnt  <= '0;
            r_err  <= 1'b0;
            r_z    <= '0;
            r_zerr <= 1'b0;
        end else if (w_accept) begin
            r_a    <= in_a;
            r_b    <= NB'(in_b);
            r_acc  <= '0;
            r_cnt  <= CW'(NDIG - 1);
            r_err  <= (in_a >= c_mod) || (in_b >= c_mod);
        end else if (r_state == S_RUN) begin
            // An out-of-range operand keeps the fixed latency but yields zero.
            r_acc <= r_err ? '0 : w_next_acc;
            r_b   <= r_b << D;
            r_cnt <= r_cnt - 1'b1;
            if (w_last) begin
                r_z    <= r_err ? '0 : w_next_acc;
                r_zerr <= r_err;
            end
        end
    end

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = (r_state == S_DONE);
    assign out_z     = r_z;
    assign out_err   = r_zerr;

endmodule

`default_nettype wire
